// File: rtl/spi_master_byte.sv
// Byte-level SPI master, mode 0 (sck idles low, data launched on the falling edge
// and captured on the rising edge). A one-deep holding register in front of the
// shifter lets back-to-back bytes stream under one chip select with no gap.
module spi_master_byte #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    output logic       sck_o,
    output logic       mosi_o,
    input  logic       miso_i,
    output logic       cs_n_o
);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StGap, StHold} state_e;

    localparam logic [7:0] DivMax = 8'(CLK_DIV - 1);

    state_e     state_q;
    logic [7:0] div_q;
    logic [3:0] half_q;
    logic [7:0] hold_data_q;
    logic       hold_last_q;
    logic       tx_ready_q;
    logic [7:0] tx_shift_q;
    logic       cur_last_q;
    logic [7:0] rx_shift_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       busy_q;
    logic       sck_q;
    logic       cs_n_q;

    logic tick;
    logic accept;
    logic load;

    assign tick   = (div_q == DivMax);
    assign accept = tx_valid_i && tx_ready_q;

    // Decide when the holding register moves into the shifter.
    always_comb begin
        load = 1'b0;
        case (state_q)
            StIdle, StGap: load = !tx_ready_q;
            // Only on the 8th falling edge of a byte that is not the last of its frame.
            StShift: load = tick && sck_q && (half_q == 4'd15) && !cur_last_q && !tx_ready_q;
            default: load = 1'b0;
        endcase
    end

    // Holding register; tx_ready_q doubles as its empty flag.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_ready_q  <= 1'b1;
            hold_data_q <= 8'h00;
            hold_last_q <= 1'b0;
        end else if (accept) begin
            tx_ready_q  <= 1'b0;
            hold_data_q <= tx_data_i;
            hold_last_q <= tx_last_i;
        end else if (load) begin
            tx_ready_q  <= 1'b1;
        end
    end

    // Half-period divider; parked at zero while no SCK edges are due.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_q == StIdle || state_q == StGap) begin
            div_q <= 8'd0;
        end else if (tick) begin
            div_q <= 8'd0;
        end else begin
            div_q <= div_q + 8'd1;
        end
    end

    // Framing FSM with registered SPI and status outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            half_q     <= 4'd0;
            tx_shift_q <= 8'h00;
            cur_last_q <= 1'b0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    cs_n_q <= 1'b1;
                    sck_q  <= 1'b0;
                    if (load) begin
                        tx_shift_q <= hold_data_q;
                        cur_last_q <= hold_last_q;
                        half_q     <= 4'd0;
                        cs_n_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StSetup;
                    end
                end
                StSetup: begin
                    if (tick) begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (tick) begin
                        sck_q  <= ~sck_q;
                        half_q <= half_q + 4'd1;
                        if (!sck_q) begin
                            rx_shift_q <= {rx_shift_q[6:0], miso_i};
                        end else if (half_q != 4'd15) begin
                            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                        end else begin
                            rx_data_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                            if (cur_last_q) begin
                                state_q <= StHold;
                            end else if (load) begin
                                tx_shift_q <= hold_data_q;
                                cur_last_q <= hold_last_q;
                            end else begin
                                state_q <= StGap;
                            end
                        end
                    end
                end
                StGap: begin
                    if (load) begin
                        tx_shift_q <= hold_data_q;
                        cur_last_q <= hold_last_q;
                        state_q    <= StShift;
                    end
                end
                StHold: begin
                    if (tick) begin
                        cs_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_ready_o = tx_ready_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = busy_q;
    assign sck_o      = sck_q;
    // MSB of the shifter is the launched bit, so mosi_o stays a register output.
    assign mosi_o     = tx_shift_q[7];
    assign cs_n_o     = cs_n_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// Bench for spi_master_byte: two instances (CLK_DIV=2 and CLK_DIV=1) checked every
// cycle against a timestamp-based model, plus literal checks on directed frames.
module tb_spi_master_byte;

    localparam int DivA = 2;
    localparam int DivB = 1;
    localparam int MIdle = 0;
    localparam int MByte = 1;
    localparam int MGap = 2;
    localparam int MHold = 3;

    logic       clk = 1'b0;
    logic       rst      [2];
    logic [7:0] tx_data  [2];
    logic       tx_last  [2];
    logic       tx_valid [2];
    logic       tx_ready [2];
    logic [7:0] rx_data  [2];
    logic       rx_valid [2];
    logic       busy     [2];
    logic       sck      [2];
    logic       mosi     [2];
    logic       miso     [2];
    logic       cs_n     [2];
    int         miso_mode [2];
    logic       miso_rnd  [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic chk_en = 1'b0;
    int log_dut = 0;
    int rxc[$];
    logic [7:0] rxd[$];
    int cs_rise [2] = '{0, 0};
    logic prev_cs [2] = '{1'b1, 1'b1};

    // Model state: position within the current byte is a cycle timestamp.
    int         m_mode [2];
    int         m_t    [2];
    int         m_off  [2];
    logic [7:0] m_byte [2];
    logic       m_last [2];
    logic [7:0] m_rx   [2];
    logic       m_hv   [2];
    logic [7:0] m_hd   [2];
    logic       m_hl   [2];
    logic       e_cs   [2];
    logic       e_sck  [2];
    logic       e_mosi [2];
    logic       e_rdy  [2];
    logic       e_rxv  [2];
    logic [7:0] e_rxd  [2];
    logic       e_busy [2];

    always #5 clk = ~clk;

    assign miso[0] = (miso_mode[0] == 0) ? mosi[0] : (miso_mode[0] == 1) ? 1'b1 : miso_rnd[0];
    assign miso[1] = (miso_mode[1] == 0) ? mosi[1] : (miso_mode[1] == 1) ? 1'b1 : miso_rnd[1];

    spi_master_byte #(.CLK_DIV(DivA)) u_dut_a (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst[0]),
        .tx_data_i  (tx_data[0]),
        .tx_last_i  (tx_last[0]),
        .tx_valid_i (tx_valid[0]),
        .tx_ready_o (tx_ready[0]),
        .rx_data_o  (rx_data[0]),
        .rx_valid_o (rx_valid[0]),
        .busy_o     (busy[0]),
        .sck_o      (sck[0]),
        .mosi_o     (mosi[0]),
        .miso_i     (miso[0]),
        .cs_n_o     (cs_n[0])
    );

    spi_master_byte #(.CLK_DIV(DivB)) u_dut_b (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst[1]),
        .tx_data_i  (tx_data[1]),
        .tx_last_i  (tx_last[1]),
        .tx_valid_i (tx_valid[1]),
        .tx_ready_o (tx_ready[1]),
        .rx_data_o  (rx_data[1]),
        .rx_valid_o (rx_valid[1]),
        .busy_o     (busy[1]),
        .sck_o      (sck[1]),
        .mosi_o     (mosi[1]),
        .miso_i     (miso[1]),
        .cs_n_o     (cs_n[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock edge of the model; sees the inputs as they were just before the edge.
    task automatic model_step(input int d);
        int   dv;
        int   s;
        int   k;
        logic hv0;
        logic [7:0] hd0;
        logic hl0;
        logic ld;
        logic mi;
        dv  = (d == 0) ? DivA : DivB;
        hv0 = m_hv[d];
        hd0 = m_hd[d];
        hl0 = m_hl[d];
        mi  = miso[d];
        ld  = 1'b0;
        if (rst[d]) begin
            m_mode[d] = MIdle;
            m_t[d]    = 0;
            m_off[d]  = 0;
            m_hv[d]   = 1'b0;
            m_rx[d]   = 8'h00;
            e_mosi[d] = 1'b0;
            e_rxd[d]  = 8'h00;
            e_rxv[d]  = 1'b0;
        end else begin
            e_rxv[d] = 1'b0;
            case (m_mode[d])
                MIdle: begin
                    if (hv0) begin
                        ld = 1'b1;
                        m_off[d] = dv;
                        m_mode[d] = MByte;
                    end
                end
                MByte: begin
                    m_t[d]++;
                    s = m_t[d] - m_off[d];
                    if (s > 0 && (s % dv) == 0 && ((s / dv) % 2) == 1) m_rx[d] = {m_rx[d][6:0], mi};
                    if (s == 16 * dv) begin
                        e_rxd[d] = m_rx[d];
                        e_rxv[d] = 1'b1;
                        if (m_last[d]) begin
                            m_mode[d] = MHold;
                            m_t[d] = 0;
                        end else if (hv0) begin
                            ld = 1'b1;
                            m_off[d] = 0;
                        end else begin
                            m_mode[d] = MGap;
                        end
                    end
                end
                MGap: begin
                    if (hv0) begin
                        ld = 1'b1;
                        m_off[d] = 0;
                        m_mode[d] = MByte;
                    end
                end
                default: begin
                    m_t[d]++;
                    if (m_t[d] == dv) m_mode[d] = MIdle;
                end
            endcase
            if (ld) begin
                m_byte[d] = hd0;
                m_last[d] = hl0;
                m_t[d] = 0;
            end
            if (tx_valid[d] && !hv0) begin
                m_hv[d] = 1'b1;
                m_hd[d] = tx_data[d];
                m_hl[d] = tx_last[d];
            end else if (ld) begin
                m_hv[d] = 1'b0;
            end
        end
        e_cs[d]   = (m_mode[d] == MIdle);
        e_busy[d] = !e_cs[d];
        e_rdy[d]  = !m_hv[d];
        e_sck[d]  = 1'b0;
        if (m_mode[d] == MByte) begin
            s = m_t[d] - m_off[d];
            if (s >= dv && ((s / dv) % 2) == 1) e_sck[d] = 1'b1;
            if (s < 0) begin
                e_mosi[d] = m_byte[d][7];
            end else begin
                k = s / (2 * dv);
                if (k > 7) k = 7;
                e_mosi[d] = m_byte[d][7 - k];
            end
        end
    endtask

    // Model advances on every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    // Compare DUT against the model mid-cycle, and log receive/CS events.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (chk_en) begin
                    chk($sformatf("d%0d cs_n", d), cs_n[d], e_cs[d]);
                    chk($sformatf("d%0d sck", d), sck[d], e_sck[d]);
                    chk($sformatf("d%0d mosi", d), mosi[d], e_mosi[d]);
                    chk($sformatf("d%0d tx_ready", d), tx_ready[d], e_rdy[d]);
                    chk($sformatf("d%0d rx_valid", d), rx_valid[d], e_rxv[d]);
                    chk($sformatf("d%0d rx_data", d), rx_data[d], e_rxd[d]);
                    chk($sformatf("d%0d busy", d), busy[d], e_busy[d]);
                end
                if (cs_n[d] === 1'b1 && prev_cs[d] === 1'b0) cs_rise[d]++;
                prev_cs[d] = cs_n[d];
                if (rx_valid[d] === 1'b1 && d == log_dut) begin
                    rxc.push_back(cyc);
                    rxd.push_back(rx_data[d]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            miso_rnd[0] = 1'($urandom_range(0, 1));
            miso_rnd[1] = 1'($urandom_range(0, 1));
        end
    end

    // Offer a byte starting at a negedge; returns at the negedge after the accept edge.
    task automatic send(input int d, input logic [7:0] b, input logic last, input bit scramble,
                        output int acc);
        int n;
        n = 0;
        tx_valid[d] = 1'b1;
        tx_data[d]  = b;
        tx_last[d]  = last;
        while (tx_ready[d] !== 1'b1 && n < 3000) begin
            if (scramble) begin
                tx_data[d] = 8'($urandom);
                tx_last[d] = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n++;
        end
        chk("send_ready", tx_ready[d], 1'b1);
        tx_data[d] = b;
        tx_last[d] = last;
        @(negedge clk);
        acc = cyc;
    endtask

    task automatic wait_rx(input int n);
        int k;
        k = 0;
        while (rxd.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("rx_count", rxd.size(), n);
    endtask

    task automatic wait_idle(input int d);
        int k;
        k = 0;
        while (!(cs_n[d] === 1'b1 && tx_ready[d] === 1'b1) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_cs_n", cs_n[d], 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic single_frame(input int d, input logic [7:0] b);
        int dv;
        int acc;
        int rel;
        int cs_lo;
        int cs_hi;
        int rxv_at;
        int rises;
        logic [7:0] bits;
        logic [7:0] got;
        logic prev;
        dv = (d == 0) ? DivA : DivB;
        cs_lo = -1;
        cs_hi = -1;
        rxv_at = -1;
        rises = 0;
        bits = 8'h00;
        got = 8'h00;
        prev = 1'b0;
        chk("single_ready", tx_ready[d], 1'b1);
        tx_valid[d] = 1'b1;
        tx_data[d]  = b;
        tx_last[d]  = 1'b1;
        @(negedge clk);
        acc = cyc;
        tx_valid[d] = 1'b0;
        for (int i = 0; i < 60; i++) begin
            rel = cyc - acc;
            if (cs_n[d] === 1'b0 && cs_lo < 0) cs_lo = rel;
            if (cs_n[d] === 1'b1 && cs_lo >= 0 && cs_hi < 0) cs_hi = rel;
            if (sck[d] === 1'b1 && prev === 1'b0) begin
                rises++;
                bits = {bits[6:0], mosi[d]};
            end
            prev = sck[d];
            if (rx_valid[d] === 1'b1) begin
                rxv_at = rel;
                got = rx_data[d];
            end
            @(negedge clk);
        end
        chk($sformatf("d%0d cs_fall_cycle", d), cs_lo, 1);
        chk($sformatf("d%0d sck_rises", d), rises, 8);
        chk($sformatf("d%0d mosi_bits", d), bits, b);
        chk($sformatf("d%0d rx_valid_cycle", d), rxv_at, 1 + 17 * dv);
        chk($sformatf("d%0d rx_byte", d), got, b);
        chk($sformatf("d%0d cs_rise_cycle", d), cs_hi, 1 + 18 * dv);
    endtask

    task automatic rand_run(input int d, input int n);
        int acc;
        int gap;
        miso_mode[d] = 2;
        for (int i = 0; i < n; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
            if (gap > 0) begin
                tx_valid[d] = 1'b0;
                repeat (gap) @(negedge clk);
            end
            send(d, 8'($urandom), (i == n - 1) ? 1'b1 : ($urandom_range(0, 3) == 0), 1'b1, acc);
        end
        tx_valid[d] = 1'b0;
        wait_idle(d);
        miso_mode[d] = 0;
    endtask

    initial begin
        int acc;
        int n0;
        int r0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            tx_data[d] = 8'h00;
            tx_last[d] = 1'b0;
            tx_valid[d] = 1'b0;
            miso_mode[d] = 0;
        end
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_cs_n", cs_n[d], 1'b1);
            chk("rst_sck", sck[d], 1'b0);
            chk("rst_mosi", mosi[d], 1'b0);
            chk("rst_tx_ready", tx_ready[d], 1'b1);
            chk("rst_rx_valid", rx_valid[d], 1'b0);
            chk("rst_rx_data", rx_data[d], 8'h00);
            chk("rst_busy", busy[d], 1'b0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        // Single A5 frame, CLK_DIV=2, loopback.
        log_dut = 0;
        single_frame(0, 8'hA5);
        wait_idle(0);

        // Three-byte stream with valid held high.
        n0 = rxd.size();
        r0 = cs_rise[0];
        send(0, 8'h01, 1'b0, 1'b0, acc);
        send(0, 8'h80, 1'b0, 1'b0, acc);
        send(0, 8'hFF, 1'b1, 1'b0, acc);
        tx_valid[0] = 1'b0;
        wait_rx(n0 + 3);
        wait_idle(0);
        if (rxd.size() >= n0 + 3) begin
            chk("stream_b0", rxd[n0], 8'h01);
            chk("stream_b1", rxd[n0 + 1], 8'h80);
            chk("stream_b2", rxd[n0 + 2], 8'hFF);
            chk("stream_gap01", rxc[n0 + 1] - rxc[n0], 16 * DivA);
            chk("stream_gap12", rxc[n0 + 2] - rxc[n0 + 1], 16 * DivA);
        end
        chk("stream_cs_rises", cs_rise[0] - r0, 1);

        // Starved stream: frame stays open in the gap.
        n0 = rxd.size();
        send(0, 8'h3C, 1'b0, 1'b0, acc);
        tx_valid[0] = 1'b0;
        wait_rx(n0 + 1);
        repeat (50) @(negedge clk);
        chk("gap_cs_n", cs_n[0], 1'b0);
        chk("gap_sck", sck[0], 1'b0);
        send(0, 8'hC3, 1'b1, 1'b0, acc);
        tx_valid[0] = 1'b0;
        wait_rx(n0 + 2);
        if (rxd.size() >= n0 + 2) begin
            chk("gap_b0", rxd[n0], 8'h3C);
            chk("gap_b1", rxd[n0 + 1], 8'hC3);
            chk("gap_resume_cycle", rxc[n0 + 1] - acc, 1 + 16 * DivA);
        end
        wait_idle(0);

        // miso tied high while sending zeros.
        n0 = rxd.size();
        miso_mode[0] = 1;
        send(0, 8'h00, 1'b1, 1'b0, acc);
        tx_valid[0] = 1'b0;
        wait_rx(n0 + 1);
        if (rxd.size() >= n0 + 1) chk("ones_rx", rxd[n0], 8'hFF);
        wait_idle(0);
        miso_mode[0] = 0;

        // Reset during bit 4, then a fresh frame.
        send(0, 8'h96, 1'b1, 1'b0, acc);
        tx_valid[0] = 1'b0;
        repeat (18) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("midrst_cs_n", cs_n[0], 1'b1);
        chk("midrst_sck", sck[0], 1'b0);
        chk("midrst_tx_ready", tx_ready[0], 1'b1);
        chk("midrst_busy", busy[0], 1'b0);
        n0 = rxd.size();
        repeat (60) @(negedge clk);
        chk("midrst_no_rx", rxd.size(), n0);
        send(0, 8'h5A, 1'b1, 1'b0, acc);
        tx_valid[0] = 1'b0;
        wait_rx(n0 + 1);
        if (rxd.size() >= n0 + 1) chk("midrst_fresh", rxd[n0], 8'h5A);
        wait_idle(0);

        // Randomized traffic with backpressure and random miso.
        rand_run(0, 25);

        // CLK_DIV=1 instance.
        log_dut = 1;
        single_frame(1, 8'hA5);
        wait_idle(1);
        rand_run(1, 25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/spi_master_byte.md
Name: spi_master_byte

Overview:
- Byte-level SPI master (mode 0) directly downstream of the I2C-slave front end in the I2C-to-SPI bridge.
- Accepts command/data bytes over a valid/ready handshake, frames them under chip select and drives sck_o/mosi_o.
- Captures miso_i and returns each received byte to the I2C side for read-back.
- Has a one-deep holding register, so back-to-back bytes stream with no gap.

Parameters:
- CLK_DIV, 2, wb_clk_i cycles per SCK half-period; legal range 1..255.

Ports:
- wb_clk_i  input  1  system clock; all logic on rising edge.
- wb_rst_i  input  1  synchronous active-high reset.
- tx_data_i  input  8  byte to transmit, MSB first.
- tx_last_i  input  1  qualifies tx_data_i: deassert CS after this byte.
- tx_valid_i  input  1  tx_data_i/tx_last_i valid.
- tx_ready_o  output  1  holding register empty; transfer occurs when valid&&ready.
- rx_data_o  output  8  last received byte; held until the next byte completes.
- rx_valid_o  output  1  one-cycle pulse when rx_data_o updates.
- busy_o  output  1  high whenever state != IDLE.
- sck_o  output  1  SPI clock; idles low.
- mosi_o  output  1  SPI data out.
- miso_i  input  1  SPI data in; synchronized externally.
- cs_n_o  output  1  active-low chip select.

Behaviour:
- All outputs are registered.
- Reset values: cs_n_o=1, sck_o=0, mosi_o=0, tx_ready_o=1, rx_valid_o=0, rx_data_o=8'h00, busy_o=0.
- Reset also empties the holding register and selects IDLE.
- Holding register: tx_ready_o = !hold_valid.
  - An accept stores data and last, sets hold_valid.
  - A load into the shifter clears hold_valid.
  - Accept and load in the same cycle keep hold_valid=1 with the new byte.
  - tx_valid_i while tx_ready_o=0 is ignored; no overwrite.
- Divider: counter 0..CLK_DIV-1. A tick occurs when it reaches CLK_DIV-1; the counter then restarts. The counter is held at 0 in IDLE and GAP.
- States and transitions:
  - IDLE: cs_n_o=1, sck_o=0. If hold_valid: load the shifter, mosi_o=bit7, cs_n_o=0, go to SETUP.
  - SETUP: wait one tick, which is the CS-to-first-edge setup time, then go to SHIFT.
  - SHIFT: each tick toggles sck_o, 16 half-periods per byte.
    - Rising edge: shift miso_i into the rx shifter LSB.
    - Falling edge, bits 1..7: mosi_o takes the next bit.
  - 8th falling edge:
    - rx_data_o <= rx shifter and rx_valid_o=1 for exactly that one cycle.
    - If latched last=1: go to HOLD.
    - Else if hold_valid: load the next byte, mosi_o=its bit7, stay in SHIFT. No extra idle half-period; the next rising edge follows after CLK_DIV cycles.
    - Else: go to GAP.
  - GAP: cs_n_o stays 0, sck_o stays 0. When hold_valid: load, mosi_o=bit7, go to SHIFT. The next rising edge follows after CLK_DIV cycles.
  - HOLD: wait one tick with cs_n_o=0, then cs_n_o=1 and go to IDLE.
  - IDLE lasts at least one cycle before a new frame, giving minimum CS-high time of 1 cycle.
- Latency for one single-byte frame, accept at cycle 0:
  - cs_n_o low at cycle 1.
  - First sck_o rise at 1+CLK_DIV.
  - 8th fall and rx_valid_o at 1+17*CLK_DIV.
  - cs_n_o high at 1+18*CLK_DIV.
  - busy_o high for cycles 1..18*CLK_DIV.
- Streaming: bytes are spaced exactly 16*CLK_DIV cycles apart while the holding register is refilled in time.
- tx_last_i is sampled only on accept; it is ignored otherwise.
- Reset mid-transfer: the next edge forces the reset values with no rx_valid_o pulse, and the partial byte is discarded.

Test Plan:
- Single byte, CLK_DIV=2, tx 8'hA5, last=1, miso_i looped to mosi_o:
  - cs_n_o falls at cycle 1, 8 SCK pulses.
  - mosi_o shows 1,0,1,0,0,1,0,1 at the rising edges.
  - rx_valid_o pulses at cycle 35 with rx_data_o=8'hA5.
  - cs_n_o rises at cycle 37.
- Stream 3 bytes 8'h01,8'h80,8'hFF, last on the third, valid held high, loopback:
  - cs_n_o low continuously.
  - rx_valid_o pulses 32 cycles apart with 01,80,FF.
  - tx_ready_o drops after the 2nd accept until the first load.
- Starved stream: byte 8'h3C with last=0, the next byte offered 50 cycles after the rx pulse:
  - GAP holds cs_n_o=0, sck_o=0.
  - Transfer resumes CLK_DIV cycles later with correct data.
- Backpressure: tx_valid_i held while tx_ready_o=0 with a changing tx_data_i → only bytes present on handshake cycles appear on mosi_o.
- miso_i tied to 1 while sending 8'h00 → rx_data_o=8'hFF and mosi_o constant 0.
- Assert wb_rst_i during bit 4:
  - Next cycle cs_n_o=1, sck_o=0, tx_ready_o=1, busy_o=0.
  - No rx_valid_o pulse.
  - A fresh 8'h5A frame afterwards completes normally.
  - Repeat the first scenario with CLK_DIV=1.
